rs_syndrome_feeder: RTL and testbench
=====================================

RS_SYNDROME_FEEDER -- requirements
Module: rs_syndrome_feeder

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-low.
REQ-002 SHALL have ports as follows, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-low reset
- din  in  8  received RS(255,239) symbol, GF(2^8)
- din_valid  in  1  symbol qualifier
- din_sop  in  1  first symbol of codeword, qualified by din_valid
- deg_Ro  out  6  degree of R(x) initial polynomial
- deg_Qo  out  6  degree of Q(x) initial polynomial
- stop_o  out  1  1 = no decoding needed or idle
- Rout  out  8  R(x) coefficient stream
- Qout  out  8  Q(x) coefficient stream
- Lout  out  8  L(x) coefficient stream
- Uout  out  8  U(x) coefficient stream
- st_out  out  1  frame start marker, active-low
- start_cnt  out  1  key-equation array enable
- busy  out  1  emission in progress
- sop_err  out  1  one-cycle pulse on premature din_sop

Function
REQ-003 SHALL use field GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D); t=8; syndromes S1..S16 at roots alpha^1..alpha^16.
REQ-004 SHALL accumulate with Horner form, first symbol = coefficient of x^254.
- S_j <= S_j*alpha^j XOR din on each accepted symbol.
- Constant multipliers are combinational.
REQ-005 SHALL accept a symbol only when din_valid=1; din_valid=0 cycles stall the accumulators and the 8-bit symbol counter, with no other effect.
REQ-006 SHALL, on din_valid&din_sop:
- load S_j <= din, ignoring prior accumulator contents;
- set symbol counter to 1.
REQ-007 SHALL pulse sop_err for one cycle when din_sop arrives with counter in 1..254; that partial codeword is discarded.
REQ-008 SHALL ignore din_valid symbols arriving before the first din_sop after reset or after completion (counter=0).
REQ-009 SHALL treat the 255th accepted symbol as codeword complete.
- In the next cycle: copy S1..S16 into the output bank, clear counter to 0, raise zero flag = (all S_j==0).
- Accumulation of the next codeword proceeds in parallel (double-buffered).
REQ-010 Emission FSM SHALL have states IDLE and EMIT with a 5-bit beat counter k=0..16.
- IDLE->EMIT: the cycle after the bank load; st_out is therefore low 2 cycles after the 255th symbol's accepting edge.
- EMIT->IDLE after k=16.
REQ-011 SHALL emit one coefficient per cycle in EMIT, highest degree first, with beat k carrying degree 16-k:
- Rout: 0x01 at k=0, else 0x00 (R=x^16).
- Qout: 0x00 at k=0, S(17-k) at k=1..16 (Q=S1+S2x+...+S16x^15).
- Lout: 0x00 for all k.
- Uout: 0x01 at k=16, else 0x00.
- st_out: 0 at k=0 only.
- deg_Ro=16 and deg_Qo=15 for all k.
- stop_o = zero flag for all k.
- busy=1 for all k.
REQ-012 SHALL drive outputs in IDLE as follows: Rout/Qout/Lout/Uout/deg_Ro/deg_Qo = 0, st_out=1, stop_o=1, busy=0.
REQ-013 SHALL set start_cnt at the first EMIT entry after reset and hold it at 1 (sticky) until reset.
REQ-014 SHALL apply the following if a bank load is due while in EMIT: the new bank load waits; overflow is impossible with 255-symbol codewords, so no further handling is required.
REQ-015 SHALL make all outputs registered; no combinational path from inputs to outputs.

Reset
REQ-016 SHALL, with reset=0 at a clock edge:
- clear accumulators, output bank, symbol counter, beat counter and zero flag;
- force IDLE;
- set start_cnt=0, sop_err=0, and outputs to REQ-012 values.
REQ-017 SHALL make reset mid-accumulation or mid-EMIT abort immediately; a partial frame is never resumed.

Verification
REQ-018 Bench SHALL cover these scenarios:
- All-zero codeword, 255 contiguous valid -> st_out low 2 cycles after last symbol; stop_o=1 for 17 cycles; Qout=0x00 all beats; Uout=0x01 at beat 16.
- Codeword zero except last symbol = 0x05 -> Qout=0x05 at beats 1..16; stop_o=0; Rout=0x01 at beat 0; deg_Ro=16, deg_Qo=15.
- Codeword zero except first symbol = 0x01 -> S1=0x8E appears on Qout at beat 16; start_cnt rises with first st_out and stays 1.
- Same as the previous scenario with din_valid toggling every other cycle -> identical output frame, shifted by the stall count.
- din_sop at symbol 100 -> sop_err pulse; next 255 symbols yield exactly one frame; no frame for the aborted codeword.
- reset=0 at EMIT beat 8 -> next cycle all outputs at REQ-012 values and start_cnt=0; no further beats emitted.

Source files
------------

// File: rtl/rs_syndrome_feeder.sv
// RS(255,239) syndrome accumulator feeding a key-equation array with R=x^16, Q=S(x), L=0, U=1.
// Frame starts 2 cycles after the last symbol; no backpressure, din_valid=0 only stalls the accumulators.
module rs_syndrome_feeder (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       din_sop,
    output logic [5:0] deg_Ro,
    output logic [5:0] deg_Qo,
    output logic       stop_o,
    output logic [7:0] Rout,
    output logic [7:0] Qout,
    output logic [7:0] Lout,
    output logic [7:0] Uout,
    output logic       st_out,
    output logic       start_cnt,
    output logic       busy,
    output logic       sop_err
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] gf_alpha(input int j);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 0; i < j; i++) r = gf_mul(r, 8'h02);
        return r;
    endfunction

    logic [7:0] syn_q  [16];
    logic [7:0] syn_d  [16];
    logic [7:0] syn_mul[16];
    logic [7:0] bank_q [16];
    logic [7:0] bank_d [16];
    logic [7:0] cnt_q, cnt_d;
    logic       sop_err_q, sop_err_d;
    logic       ld_pend_q, ld_pend_d;
    logic       go_q, go_d;
    logic       zero_q, zero_d;
    logic       sop_acc, cplt, bank_ld, all_zero;

    for (genvar g = 0; g < 16; g++) begin : g_mul
        localparam logic [7:0] ALPHA_J = gf_alpha(g + 1);
        assign syn_mul[g] = gf_mul(syn_q[g], ALPHA_J);
    end

    assign sop_acc = din_valid & din_sop;
    // cnt_q == 255 marks a finished codeword for exactly one cycle
    assign cplt    = (cnt_q == 8'd255);

    always_comb begin
        cnt_d     = cnt_q;
        syn_d     = syn_q;
        sop_err_d = sop_acc & (cnt_q != 8'd0) & (cnt_q != 8'd255);
        if (sop_acc) begin
            cnt_d = 8'd1;
            for (int i = 0; i < 16; i++) syn_d[i] = din;
        end else if (cplt) begin
            cnt_d = 8'd0;
        end else if (din_valid && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q + 8'd1;
            for (int i = 0; i < 16; i++) syn_d[i] = syn_mul[i] ^ din;
        end
    end

    always_comb begin
        all_zero = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (syn_q[i] != 8'h00) all_zero = 1'b0;
        end
    end

    state_t     state_q, state_d;
    logic [4:0] k_q, k_d;

    // The bank is only rewritten while idle so an in-flight frame never sees new data
    assign bank_ld = (cplt | ld_pend_q) & (state_q == S_IDLE) & ~go_q;

    always_comb begin
        bank_d    = bank_q;
        ld_pend_d = (ld_pend_q | cplt) & ~bank_ld;
        go_d      = bank_ld;
        zero_d    = zero_q;
        if (bank_ld) begin
            bank_d = syn_q;
            zero_d = all_zero;
        end
    end

    logic [7:0] rout_q, rout_d, qout_q, qout_d, lout_q, lout_d, uout_q, uout_d;
    logic [5:0] deg_r_q, deg_r_d, deg_q_q, deg_q_d;
    logic       stop_q, stop_d, st_q, st_d, busy_q, busy_d, start_q, start_d;
    logic [4:0] qidx;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (go_q) begin
                    state_d = S_EMIT;
                    k_d     = 5'd0;
                end
            end
            S_EMIT: begin
                if (k_q == 5'd16) begin
                    state_d = S_IDLE;
                    k_d     = 5'd0;
                end else begin
                    k_d = k_q + 5'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                k_d     = 5'd0;
            end
        endcase
    end

    always_comb begin
        rout_d  = 8'h00;
        qout_d  = 8'h00;
        lout_d  = 8'h00;
        uout_d  = 8'h00;
        deg_r_d = 6'd0;
        deg_q_d = 6'd0;
        stop_d  = 1'b1;
        st_d    = 1'b1;
        busy_d  = 1'b0;
        start_d = start_q;
        qidx    = 5'd16 - k_d;
        if (state_d == S_EMIT) begin
            // Beat k carries degree 16-k; S(17-k) sits at bank index 16-k
            rout_d  = (k_d == 5'd0) ? 8'h01 : 8'h00;
            qout_d  = (k_d == 5'd0) ? 8'h00 : bank_q[qidx[3:0]];
            uout_d  = (k_d == 5'd16) ? 8'h01 : 8'h00;
            deg_r_d = 6'd16;
            deg_q_d = 6'd15;
            stop_d  = zero_q;
            st_d    = (k_d != 5'd0);
            busy_d  = 1'b1;
            start_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q     <= 8'd0;
            sop_err_q <= 1'b0;
            ld_pend_q <= 1'b0;
            go_q      <= 1'b0;
            zero_q    <= 1'b0;
            state_q   <= S_IDLE;
            k_q       <= 5'd0;
            for (int i = 0; i < 16; i++) begin
                syn_q[i]  <= 8'h00;
                bank_q[i] <= 8'h00;
            end
            rout_q    <= 8'h00;
            qout_q    <= 8'h00;
            lout_q    <= 8'h00;
            uout_q    <= 8'h00;
            deg_r_q   <= 6'd0;
            deg_q_q   <= 6'd0;
            stop_q    <= 1'b1;
            st_q      <= 1'b1;
            busy_q    <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            sop_err_q <= sop_err_d;
            ld_pend_q <= ld_pend_d;
            go_q      <= go_d;
            zero_q    <= zero_d;
            state_q   <= state_d;
            k_q       <= k_d;
            for (int i = 0; i < 16; i++) begin
                syn_q[i]  <= syn_d[i];
                bank_q[i] <= bank_d[i];
            end
            rout_q    <= rout_d;
            qout_q    <= qout_d;
            lout_q    <= lout_d;
            uout_q    <= uout_d;
            deg_r_q   <= deg_r_d;
            deg_q_q   <= deg_q_d;
            stop_q    <= stop_d;
            st_q      <= st_d;
            busy_q    <= busy_d;
            start_q   <= start_d;
        end
    end

    assign deg_Ro    = deg_r_q;
    assign deg_Qo    = deg_q_q;
    assign stop_o    = stop_q;
    assign Rout      = rout_q;
    assign Qout      = qout_q;
    assign Lout      = lout_q;
    assign Uout      = uout_q;
    assign st_out    = st_q;
    assign start_cnt = start_q;
    assign busy      = busy_q;
    assign sop_err   = sop_err_q;

endmodule

// File: tb/tb_rs_syndrome_feeder.sv
// Bench for rs_syndrome_feeder: directed and random codewords against a log/antilog syndrome model.
module tb_rs_syndrome_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid;
    logic       din_sop;
    logic [5:0] deg_Ro, deg_Qo;
    logic       stop_o;
    logic [7:0] Rout, Qout, Lout, Uout;
    logic       st_out, start_cnt, busy, sop_err;

    rs_syndrome_feeder dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_sop(din_sop),
        .deg_Ro(deg_Ro), .deg_Qo(deg_Qo), .stop_o(stop_o), .Rout(Rout), .Qout(Qout),
        .Lout(Lout), .Uout(Uout), .st_out(st_out), .start_cnt(start_cnt), .busy(busy),
        .sop_err(sop_err)
    );

    always #5 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] gexp [255];
    int         glog [256];
    logic [7:0] cw   [255];
    logic [7:0] exp_s[17];
    logic       sop_err_first, sop_err_second, sc_pre;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return gexp[(glog[a] + glog[b]) % 255];
    endfunction

    // S_j = R(alpha^j), with cw[0] the coefficient of x^254
    task automatic model();
        logic [7:0] s;
        for (int j = 1; j <= 16; j++) begin
            s = 8'h00;
            for (int i = 0; i < 255; i++) s = s ^ gm(cw[i], gexp[(j * (254 - i)) % 255]);
            exp_s[j] = s;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            din_valid = 1'b0;
            din_sop   = 1'b0;
            din       = 8'($urandom);
            step();
        end
    endtask

    // mode 0: contiguous, 1: one idle cycle between symbols, 2: random gaps
    task automatic drive_cw(input int mode);
        for (int i = 0; i < 255; i++) begin
            if (i > 0 && mode == 1) idle(1);
            if (i > 0 && mode == 2) idle(int'($urandom_range(0, 2)));
            din_valid = 1'b1;
            din       = cw[i];
            din_sop   = (i == 0);
            step();
            if (i == 0) sop_err_first = sop_err;
            if (i == 1) sop_err_second = sop_err;
        end
        din_valid = 1'b0;
        din_sop   = 1'b0;
    endtask

    task automatic chk_idle(input string nm, input logic sc_exp);
        chk({nm, " Rout"}, 32'(Rout), 32'h0);
        chk({nm, " Qout"}, 32'(Qout), 32'h0);
        chk({nm, " Lout"}, 32'(Lout), 32'h0);
        chk({nm, " Uout"}, 32'(Uout), 32'h0);
        chk({nm, " degR"}, 32'(deg_Ro), 32'h0);
        chk({nm, " degQ"}, 32'(deg_Qo), 32'h0);
        chk({nm, " st_out"}, 32'(st_out), 32'h1);
        chk({nm, " stop_o"}, 32'(stop_o), 32'h1);
        chk({nm, " busy"}, 32'(busy), 32'h0);
        chk({nm, " start_cnt"}, 32'(start_cnt), 32'(sc_exp));
    endtask

    task automatic wait_st(output int lat);
        lat    = 0;
        sc_pre = start_cnt;
        do begin
            step();
            lat++;
            if (st_out !== 1'b0) sc_pre = start_cnt;
        end while (st_out !== 1'b0 && lat < 10);
    endtask

    task automatic check_frame(input string nm);
        int   lat;
        logic zero;
        zero = 1'b1;
        for (int j = 1; j <= 16; j++) if (exp_s[j] != 8'h00) zero = 1'b0;
        wait_st(lat);
        chk({nm, " latency"}, 32'(lat), 32'd2);
        if (st_out !== 1'b0) return;
        for (int k = 0; k <= 16; k++) begin
            if (k > 0) step();
            chk($sformatf("%s R k%0d", nm, k), 32'(Rout), (k == 0) ? 32'h1 : 32'h0);
            chk($sformatf("%s Q k%0d", nm, k), 32'(Qout), (k == 0) ? 32'h0 : 32'(exp_s[17 - k]));
            chk($sformatf("%s L k%0d", nm, k), 32'(Lout), 32'h0);
            chk($sformatf("%s U k%0d", nm, k), 32'(Uout), (k == 16) ? 32'h1 : 32'h0);
            chk($sformatf("%s st k%0d", nm, k), 32'(st_out), (k == 0) ? 32'h0 : 32'h1);
            chk($sformatf("%s stop k%0d", nm, k), 32'(stop_o), 32'(zero));
            chk($sformatf("%s busy k%0d", nm, k), 32'(busy), 32'h1);
            chk($sformatf("%s degR k%0d", nm, k), 32'(deg_Ro), 32'd16);
            chk($sformatf("%s degQ k%0d", nm, k), 32'(deg_Qo), 32'd15);
        end
        step();
        chk_idle({nm, " after"}, 1'b1);
    endtask

    task automatic quiet(input string nm, input int n);
        int act;
        act = 0;
        for (int c = 0; c < n; c++) begin
            step();
            if (busy !== 1'b0 || st_out !== 1'b1) act++;
        end
        chk({nm, " no frame"}, 32'(act), 32'd0);
    endtask

    initial begin
        int lat;
        int x;
        x = 1;
        for (int i = 0; i < 255; i++) begin
            gexp[i] = 8'(x);
            glog[x] = i;
            x = (x << 1) ^ (((x & 'h80) != 0) ? 'h11D : 0);
        end
        for (int j = 0; j < 17; j++) exp_s[j] = 8'h00;

        reset = 1'b0; din = 8'h00; din_valid = 1'b0; din_sop = 1'b0;
        repeat (3) step();
        chk_idle("reset", 1'b0);
        chk("reset sop_err", 32'(sop_err), 32'h0);
        reset = 1'b1;

        // Valid symbols without any sop must be ignored
        for (int i = 0; i < 260; i++) begin
            din_valid = 1'b1; din = 8'($urandom); din_sop = 1'b0;
            step();
        end
        din_valid = 1'b0;
        quiet("presop", 5);

        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
        model();
        drive_cw(0);
        chk("zero sop_err", 32'(sop_err_first), 32'h0);
        check_frame("zero");
        idle(3);

        cw[254] = 8'h05;
        model();
        drive_cw(0);
        check_frame("last05");
        idle(3);

        reset = 1'b0; step(); reset = 1'b1;
        chk("rst2 start_cnt", 32'(start_cnt), 32'h0);
        for (int i = 0; i < 255; i++) cw[i] = 8'h00;
        cw[0] = 8'h01;
        model();
        drive_cw(0);
        check_frame("first01");
        chk("first01 start_cnt pre", 32'(sc_pre), 32'h0);
        chk("first01 start_cnt post", 32'(start_cnt), 32'h1);
        idle(3);

        drive_cw(1);
        check_frame("first01 toggle");
        chk("toggle start_cnt", 32'(start_cnt), 32'h1);
        idle(2);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 255; i++) cw[i] = 8'($urandom);
            model();
            drive_cw(2);
            check_frame($sformatf("rand%0d", r));
            idle(int'($urandom_range(1, 4)));
        end

        // Abort: sop lands on the 100th symbol of a partial codeword
        for (int i = 0; i < 99; i++) begin
            din_valid = 1'b1; din = 8'($urandom); din_sop = (i == 0);
            step();
        end
        for (int i = 0; i < 255; i++) cw[i] = 8'($urandom);
        model();
        drive_cw(0);
        chk("abort sop_err pulse", 32'(sop_err_first), 32'h1);
        chk("abort sop_err clear", 32'(sop_err_second), 32'h0);
        check_frame("abort");
        quiet("abort", 30);

        for (int i = 0; i < 255; i++) cw[i] = 8'($urandom);
        model();
        drive_cw(0);
        wait_st(lat);
        chk("rstmid latency", 32'(lat), 32'd2);
        repeat (8) step();
        chk("rstmid beat8 Q", 32'(Qout), 32'(exp_s[9]));
        reset = 1'b0;
        step();
        chk_idle("rstmid", 1'b0);
        chk("rstmid sop_err", 32'(sop_err), 32'h0);
        reset = 1'b1;
        quiet("rstmid", 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
